// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one data-bus request per memory instruction,
// aligns/extends load data and hands a single writeback record to the next stage.
package mem_access_pkg;
  typedef enum logic [4:0] {
    OP_NOP, OP_ADD, OP_ADDI, OP_LUI, OP_JAL, OP_BEQ, OP_BNE,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD
  } instruction_type;
endpackage

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  instruction_type  in_op,
  input  logic [XLEN-1:0]  in_addr,
  input  logic [XLEN-1:0]  in_data,
  input  logic [REG_W-1:0] in_rd,
  output logic             dbus_valid,
  output logic [XLEN-1:0]  dbus_addr,
  output logic [1:0]       dbus_size,
  output logic [7:0]       dbus_strobe,
  output logic [XLEN-1:0]  dbus_wdata,
  input  logic             dbus_data_ok,
  input  logic [XLEN-1:0]  dbus_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [REG_W-1:0] out_rd,
  output logic             out_write_reg,
  output logic             out_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state, state_next;

  logic       is_load, is_store, is_mem, ld_signed, alu_write, misaligned;
  logic [1:0] size;
  logic [2:0] off;
  logic [7:0] strobe_base;

  logic            load_q, signed_q;
  logic [1:0]      size_q;
  logic [2:0]      off_q;
  logic [XLEN-1:0] raw, load_result;

  // Decode of the offered instruction
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    ld_signed = 1'b0;
    alu_write = 1'b0;
    size      = 2'd0;
    case (in_op)
      OP_LB:   begin is_load = 1'b1; ld_signed = 1'b1; size = 2'd0; end
      OP_LH:   begin is_load = 1'b1; ld_signed = 1'b1; size = 2'd1; end
      OP_LW:   begin is_load = 1'b1; ld_signed = 1'b1; size = 2'd2; end
      OP_LD:   begin is_load = 1'b1; size = 2'd3; end
      OP_LBU:  begin is_load = 1'b1; size = 2'd0; end
      OP_LHU:  begin is_load = 1'b1; size = 2'd1; end
      OP_LWU:  begin is_load = 1'b1; size = 2'd2; end
      OP_SB:   begin is_store = 1'b1; size = 2'd0; end
      OP_SH:   begin is_store = 1'b1; size = 2'd1; end
      OP_SW:   begin is_store = 1'b1; size = 2'd2; end
      OP_SD:   begin is_store = 1'b1; size = 2'd3; end
      OP_ADD, OP_ADDI, OP_LUI, OP_JAL: alu_write = 1'b1;
      default: ;
    endcase
    is_mem = is_load | is_store;
    off    = in_addr[2:0];
    case (size)
      2'd0:    begin misaligned = 1'b0;            strobe_base = 8'h01; end
      2'd1:    begin misaligned = in_addr[0];      strobe_base = 8'h03; end
      2'd2:    begin misaligned = |in_addr[1:0];   strobe_base = 8'h0F; end
      default: begin misaligned = |in_addr[2:0];   strobe_base = 8'hFF; end
    endcase
  end

  // Load alignment and extension from the lane selected at accept time
  always_comb begin
    raw = dbus_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    load_result = {{(XLEN-8){signed_q & raw[7]}}, raw[7:0]};
      2'd1:    load_result = {{(XLEN-16){signed_q & raw[15]}}, raw[15:0]};
      2'd2:    load_result = {{(XLEN-32){signed_q & raw[31]}}, raw[31:0]};
      default: load_result = raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    dbus_valid = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (is_mem && !misaligned) ? REQ : DONE;
      end
      REQ: begin
        dbus_valid = 1'b1;
        if (dbus_data_ok) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request and writeback registers are only written at accept and at response,
  // so they stay stable while waiting on the bus or on the writeback stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      dbus_addr     <= '0;
      dbus_size     <= '0;
      dbus_strobe   <= '0;
      dbus_wdata    <= '0;
      out_data      <= '0;
      out_rd        <= '0;
      out_write_reg <= 1'b0;
      out_misalign  <= 1'b0;
      load_q        <= 1'b0;
      signed_q      <= 1'b0;
      size_q        <= '0;
      off_q         <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          out_rd   <= in_rd;
          load_q   <= is_load;
          signed_q <= ld_signed;
          size_q   <= size;
          off_q    <= off;
          if (is_mem && !misaligned) begin
            dbus_addr     <= {in_addr[XLEN-1:3], 3'b000};
            dbus_size     <= size;
            dbus_strobe   <= is_store ? (strobe_base << off) : 8'h00;
            dbus_wdata    <= is_store ? (in_data << {off, 3'b000}) : '0;
            out_data      <= '0;
            out_write_reg <= is_load;
            out_misalign  <= 1'b0;
          end else if (is_mem) begin
            out_data      <= '0;
            out_write_reg <= 1'b0;
            out_misalign  <= 1'b1;
          end else begin
            out_data      <= in_data;
            out_write_reg <= alu_write;
            out_misalign  <= 1'b0;
          end
        end
        REQ: if (dbus_data_ok && load_q) out_data <= load_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, randomized
// transactions against a byte-level reference model, and reset corner cases.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  instruction_type in_op;
  logic [63:0]     in_addr, in_data;
  logic [4:0]      in_rd;
  logic            dbus_valid;
  logic [63:0]     dbus_addr;
  logic [1:0]      dbus_size;
  logic [7:0]      dbus_strobe;
  logic [63:0]     dbus_wdata;
  logic            dbus_data_ok;
  logic [63:0]     dbus_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [63:0]     out_data;
  logic [4:0]      out_rd;
  logic            out_write_reg;
  logic            out_misalign;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.XLEN(64), .REG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_data(in_data), .in_rd(in_rd),
    .dbus_valid(dbus_valid), .dbus_addr(dbus_addr), .dbus_size(dbus_size),
    .dbus_strobe(dbus_strobe), .dbus_wdata(dbus_wdata),
    .dbus_data_ok(dbus_data_ok), .dbus_rdata(dbus_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_write_reg(out_write_reg), .out_misalign(out_misalign)
  );

  typedef struct {
    string           name;
    instruction_type op;
    logic [63:0]     addr, data, rdata;
    logic [4:0]      rd;
    int              delay, hold;
    bit              exp_bus;
    logic [63:0]     exp_addr;
    logic [1:0]      exp_size;
    logic [7:0]      exp_strobe;
    logic [63:0]     exp_wdata, exp_out;
    bit              exp_wr, exp_mis;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t entry(string name, instruction_type op, logic [63:0] addr, data,
                                 logic [4:0] rd, logic [63:0] rdata, int delay, hold,
                                 bit bus, logic [63:0] eaddr, logic [1:0] esize,
                                 logic [7:0] estrobe, logic [63:0] ewdata, eout,
                                 bit ewr, emis);
    vec_t v;
    v.name = name; v.op = op; v.addr = addr; v.data = data; v.rd = rd; v.rdata = rdata;
    v.delay = delay; v.hold = hold; v.exp_bus = bus; v.exp_addr = eaddr; v.exp_size = esize;
    v.exp_strobe = estrobe; v.exp_wdata = ewdata; v.exp_out = eout; v.exp_wr = ewr; v.exp_mis = emis;
    return v;
  endfunction

  // Reference model: works on byte counts and individual byte lanes.
  function automatic vec_t model(string name, instruction_type op, logic [63:0] addr, data,
                                 logic [4:0] rd, logic [63:0] rdata, int delay, hold);
    vec_t v;
    int nb, off;
    bit ld, sg, wr;
    logic [63:0] val;
    v = entry(name, op, addr, data, rd, rdata, delay, hold, 0, 0, 0, 0, 0, 0, 0, 0);
    nb = 0; ld = 0; sg = 0; wr = 0;
    case (op)
      OP_LB:  begin nb = 1; ld = 1; sg = 1; end
      OP_LH:  begin nb = 2; ld = 1; sg = 1; end
      OP_LW:  begin nb = 4; ld = 1; sg = 1; end
      OP_LD:  begin nb = 8; ld = 1; end
      OP_LBU: begin nb = 1; ld = 1; end
      OP_LHU: begin nb = 2; ld = 1; end
      OP_LWU: begin nb = 4; ld = 1; end
      OP_SB:  nb = 1;
      OP_SH:  nb = 2;
      OP_SW:  nb = 4;
      OP_SD:  nb = 8;
      OP_ADD, OP_ADDI, OP_LUI, OP_JAL: wr = 1;
      default: ;
    endcase
    off = int'(addr % 8);
    if (nb == 0) begin
      v.exp_out = data;
      v.exp_wr = wr;
    end else if (addr % nb != 0) begin
      v.exp_mis = 1;
    end else begin
      v.exp_bus = 1;
      v.exp_addr = addr - off;
      v.exp_size = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : (nb == 4) ? 2'd2 : 2'd3;
      if (ld) begin
        v.exp_wr = 1;
        val = 0;
        for (int i = 0; i < nb; i++) val = val + (64'(rdata[8*(off+i) +: 8]) << (8*i));
        if (sg && nb < 8 && val >= (64'd1 << (8*nb - 1))) val = val - (64'd1 << (8*nb));
        v.exp_out = val;
      end else begin
        for (int i = 0; i < nb; i++) v.exp_strobe[off+i] = 1'b1;
        for (int i = 0; off + i < 8; i++) v.exp_wdata[8*(off+i) +: 8] = data[8*i +: 8];
      end
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one full transaction: accept, optional bus phase, held writeback, release.
  task automatic applyStimulus(input vec_t v);
    in_op = v.op; in_addr = v.addr; in_data = v.data; in_rd = v.rd; in_valid = 1'b1;
    checkOutput({v.name, " in_ready idle"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    in_addr = {$urandom, $urandom};
    in_data = {$urandom, $urandom};
    checkOutput({v.name, " dbus_valid T+1"}, dbus_valid, v.exp_bus);
    if (v.exp_bus) begin
      for (int c = 0; c <= v.delay; c++) begin
        checkOutput({v.name, " dbus_valid"}, dbus_valid, 1);
        checkOutput({v.name, " dbus_addr"}, dbus_addr, v.exp_addr);
        checkOutput({v.name, " dbus_size"}, dbus_size, v.exp_size);
        checkOutput({v.name, " dbus_strobe"}, dbus_strobe, v.exp_strobe);
        if (v.exp_strobe != 0) checkOutput({v.name, " dbus_wdata"}, dbus_wdata, v.exp_wdata);
        checkOutput({v.name, " out_valid in REQ"}, out_valid, 0);
        checkOutput({v.name, " in_ready in REQ"}, in_ready, 0);
        if (c == v.delay) begin
          dbus_data_ok = 1'b1;
          dbus_rdata = v.rdata;
        end
        step();
        dbus_data_ok = 1'b0;
        dbus_rdata = {$urandom, $urandom};
      end
      checkOutput({v.name, " dbus_valid after ok"}, dbus_valid, 0);
    end
    for (int h = 0; h <= v.hold; h++) begin
      checkOutput({v.name, " out_valid"}, out_valid, 1);
      checkOutput({v.name, " out_rd"}, out_rd, v.rd);
      checkOutput({v.name, " out_write_reg"}, out_write_reg, v.exp_wr);
      checkOutput({v.name, " out_misalign"}, out_misalign, v.exp_mis);
      if (!v.exp_mis) checkOutput({v.name, " out_data"}, out_data, v.exp_out);
      checkOutput({v.name, " in_ready in DONE"}, in_ready, 0);
      dbus_data_ok = (h < v.hold);
      out_ready = (h == v.hold);
      step();
      dbus_data_ok = 1'b0;
      out_ready = 1'b0;
    end
    checkOutput({v.name, " out_valid released"}, out_valid, 0);
    checkOutput({v.name, " in_ready released"}, in_ready, 1);
  endtask

  initial begin
    instruction_type ops[18];
    instruction_type op;
    logic [63:0] addr;

    reset = 1'b1; in_valid = 1'b0; in_op = OP_NOP; in_addr = '0; in_data = '0; in_rd = '0;
    dbus_data_ok = 1'b0; dbus_rdata = '0; out_ready = 1'b0;
    repeat (2) step();
    checkOutput("reset dbus_valid", dbus_valid, 0);
    checkOutput("reset dbus_addr", dbus_addr, 0);
    checkOutput("reset dbus_size", dbus_size, 0);
    checkOutput("reset dbus_strobe", dbus_strobe, 0);
    checkOutput("reset dbus_wdata", dbus_wdata, 0);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_data", out_data, 0);
    checkOutput("reset out_rd", out_rd, 0);
    checkOutput("reset out_write_reg", out_write_reg, 0);
    checkOutput("reset out_misalign", out_misalign, 0);
    reset = 1'b0;
    step();
    checkOutput("reset in_ready", in_ready, 1);

    tbl.push_back(entry("LB", OP_LB, 64'h1003, 64'h0, 5'd1, 64'h0000_0000_8000_0000, 0, 0,
                        1, 64'h1000, 2'd0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1, 0));
    tbl.push_back(entry("LHU", OP_LHU, 64'h2006, 64'h0, 5'd2, 64'hBEEF_0000_0000_0000, 5, 0,
                        1, 64'h2000, 2'd1, 8'h00, 64'h0, 64'h0000_0000_0000_BEEF, 1, 0));
    tbl.push_back(entry("SW", OP_SW, 64'h3004, 64'h1122_3344, 5'd3, 64'h0, 1, 1,
                        1, 64'h3000, 2'd2, 8'hF0, 64'h1122_3344_0000_0000, 64'h0, 0, 0));
    tbl.push_back(entry("LD misaligned", OP_LD, 64'h4004, 64'h0, 5'd4, 64'h0, 0, 0,
                        0, 64'h0, 2'd0, 8'h00, 64'h0, 64'h0, 0, 1));
    tbl.push_back(entry("ADDI", OP_ADDI, 64'h0, 64'd42, 5'd7, 64'h0, 0, 3,
                        0, 64'h0, 2'd0, 8'h00, 64'h0, 64'd42, 1, 0));
    tbl.push_back(entry("SD", OP_SD, 64'h5000, 64'hDEAD_BEEF_CAFE_F00D, 5'd8, 64'h0, 2, 0,
                        1, 64'h5000, 2'd3, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 0, 0));
    tbl.push_back(entry("LW", OP_LW, 64'h6004, 64'h0, 5'd9, 64'h8765_4321_0000_0000, 0, 0,
                        1, 64'h6000, 2'd2, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321, 1, 0));
    tbl.push_back(entry("LBU", OP_LBU, 64'h0007, 64'h0, 5'd10, 64'hAB00_0000_0000_0000, 0, 0,
                        1, 64'h0000, 2'd0, 8'h00, 64'h0, 64'h0000_0000_0000_00AB, 1, 0));
    tbl.push_back(entry("SB", OP_SB, 64'h8005, 64'h1234, 5'd11, 64'h0, 0, 0,
                        1, 64'h8000, 2'd0, 8'h20, 64'h0012_3400_0000_0000, 64'h0, 0, 0));
    tbl.push_back(entry("SH misaligned", OP_SH, 64'h0011, 64'h55, 5'd12, 64'h0, 0, 1,
                        0, 64'h0, 2'd0, 8'h00, 64'h0, 64'h0, 0, 1));
    tbl.push_back(entry("BEQ", OP_BEQ, 64'h0, 64'h77, 5'd13, 64'h0, 0, 0,
                        0, 64'h0, 2'd0, 8'h00, 64'h0, 64'h77, 0, 0));
    foreach (tbl[i]) applyStimulus(tbl[i]);

    for (int i = 0; i < 18; i++) ops[i] = instruction_type'(i);
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 17)];
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) addr[2:0] = 3'd0;
      applyStimulus(model($sformatf("rand%0d", i), op, addr, {$urandom, $urandom},
                          5'($urandom), {$urandom, $urandom},
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 2))));
    end

    // Reset while a request is outstanding, then a stale response.
    in_op = OP_LD; in_addr = 64'h100; in_data = '0; in_rd = 5'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checkOutput("rstreq dbus_valid before", dbus_valid, 1);
    reset = 1'b1;
    step();
    checkOutput("rstreq dbus_valid", dbus_valid, 0);
    checkOutput("rstreq out_valid", out_valid, 0);
    checkOutput("rstreq dbus_addr", dbus_addr, 0);
    reset = 1'b0;
    dbus_data_ok = 1'b1;
    dbus_rdata = 64'h1234_5678_9ABC_DEF0;
    step();
    dbus_data_ok = 1'b0;
    checkOutput("rstreq stale ok dbus_valid", dbus_valid, 0);
    checkOutput("rstreq stale ok out_valid", out_valid, 0);
    checkOutput("rstreq in_ready", in_ready, 1);
    step();
    checkOutput("idle ok ignored out_valid", out_valid, 0);
    checkOutput("idle ok ignored out_data", out_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit that executes decoded memory instructions against the data bus. It accepts one instruction per transaction from the execute stage: an operation code, effective address, store data and destination register. It then issues a single request on the data bus and waits for the response. Load results are aligned and extended, and the unit presents one writeback record to the next stage. Non-memory instructions pass through without bus activity.

## Interface
Parameters:
- XLEN, 64, data/address width
- REG_W, 5, register index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage offers an instruction
- in_ready  out  1  unit can accept
- in_op  in  instruction_type  decoded operation
- in_addr  in  XLEN  effective address (loads/stores); ignored otherwise
- in_data  in  XLEN  store data (stores) or ALU result (non-memory ops)
- in_rd  in  REG_W  destination register
- dbus_valid  out  1  request valid
- dbus_addr  out  XLEN  request address, {in_addr[63:3], 3'b0}
- dbus_size  out  2  0=byte, 1=half, 2=word, 3=dword
- dbus_strobe  out  8  byte write enables; 0 for loads
- dbus_wdata  out  XLEN  lane-shifted store data
- dbus_data_ok  in  1  response/completion strobe
- dbus_rdata  in  XLEN  aligned 64-bit read data
- out_valid  out  1  writeback record valid
- out_ready  in  1  writeback stage accepts
- out_data  out  XLEN  load result or passed-through value
- out_rd  out  REG_W  destination register
- out_write_reg  out  1  record writes the register file
- out_misalign  out  1  access was misaligned; no bus access made

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid:
    - Latch op, address, data and rd.
    - Memory op, aligned → REQ.
    - Memory op, misaligned → DONE with out_misalign=1 and out_write_reg=0.
    - Non-memory op → DONE with out_data=in_data and out_write_reg = register-write classification of in_op.
- REQ:
  - dbus_valid=1. Address, size, strobe and wdata are registered and held stable until dbus_data_ok.
  - On dbus_data_ok, capture the load result → DONE.
- DONE:
  - out_valid=1. The record is held stable until out_ready.
  - On out_ready → IDLE.
- Sizes:
  - LB/LBU/SB = 0, LH/LHU/SH = 1, LW/LWU/SW = 2, LD/SD = 3.
- Alignment:
  - A size-n access is misaligned if the low n bits of in_addr are nonzero.
- Byte offset:
  - off = in_addr[2:0].
- Store:
  - dbus_wdata = in_data << (8*off).
  - dbus_strobe = (SB 8'h01, SH 8'h03, SW 8'h0F, SD 8'hFF) << off.
- Load:
  - Shift raw = dbus_rdata >> (8*off).
  - LB/LH/LW sign-extend from bit 7/15/31.
  - LBU/LHU/LWU zero-extend.
  - LD takes raw as is.
  - out_write_reg=1.
- Stores: out_write_reg=0, out_data=0.
- Reset:
  - State returns to IDLE.
  - in_ready=1 the cycle after reset deasserts.
  - All other outputs are 0: dbus_valid, dbus_strobe, dbus_addr, dbus_wdata, dbus_size, out_valid, out_data, out_rd, out_write_reg, out_misalign.
  - Reset mid-REQ drops dbus_valid the next cycle; any later dbus_data_ok is ignored.
- dbus_data_ok outside REQ is ignored.

## Timing
- Accept at edge T (in_valid & in_ready): dbus_valid=1 from T+1.
- dbus_data_ok at cycle T+k (k≥1): out_valid from T+k+1.
- Minimum load/store latency is 2 cycles from accept to out_valid.
- Non-memory or misaligned op: out_valid at T+1.
- in_ready=0 in REQ and DONE. The unit holds one instruction at a time; accept is never simultaneous with out_valid.
- dbus_valid deasserts in the cycle after dbus_data_ok.
- dbus_data_ok in the first REQ cycle is legal.
- out_ready held low keeps DONE indefinitely with all out_* stable.

## Test plan
- LB, addr 0x1003, dbus_rdata 0x0000_0000_8000_0000 → dbus_size 0, dbus_addr 0x1000, strobe 0x00; out_data 0xFFFF_FFFF_FFFF_FF80, out_write_reg 1.
- LHU, addr 0x2006, rdata 0xBEEF_0000_0000_0000, data_ok delayed 5 cycles → dbus_* stable for 5 cycles; out_data 0xBEEF.
- SW, addr 0x3004, in_data 0x1122_3344 → strobe 0xF0, wdata 0x1122_3344_0000_0000, size 2; out_write_reg 0.
- LD, addr 0x4004 → no dbus_valid; out_valid at T+1 with out_misalign 1, out_write_reg 0.
- ADDI, in_data 42, rd 7 → out_valid at T+1, out_data 42, out_rd 7, out_write_reg 1; out_ready held low 3 cycles keeps the record stable and in_ready 0.
- reset asserted during REQ, then dbus_data_ok pulsed → dbus_valid 0 and out_valid 0 after reset; in_ready 1 after reset deasserts.
